// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stall/bubble, branch flush,
// EX operand forwarding, ID-stage write-through bypass and saturating event counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW     = 4,
  parameter int READ_PORTS = 2,
  parameter int CNT_W      = 16,
  parameter int ZERO_REG   = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           hold,
  input  logic                           id_valid,
  input  logic [READ_PORTS*REG_AW-1:0]   id_src,
  input  logic [READ_PORTS-1:0]          id_src_used,
  input  logic [REG_AW-1:0]              id_dst,
  input  logic                           id_regWrite,
  input  logic                           id_memRead,
  input  logic                           ex_branchTaken,
  output logic                           stall,
  output logic                           bubble,
  output logic                           flush,
  output logic [2*READ_PORTS-1:0]        forward,
  output logic [READ_PORTS-1:0]          rf_bypass,
  output logic [CNT_W-1:0]               stall_count,
  output logic [CNT_W-1:0]               flush_count
);

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic              reg_write;
    logic              mem_read;
  } rec_t;

  // vld_pipe[0]=EX, [1]=MEM, [2]=WB
  logic [2:0]                      vld_pipe;
  rec_t                            ex_r, mem_r, wb_r;
  logic [READ_PORTS*REG_AW-1:0]    ex_src;
  logic [READ_PORTS-1:0]           ex_used;
  logic [READ_PORTS-1:0]           load_use;
  logic                            hazard;

  // The load flag is only consulted in EX; the WB copy just rides along.
  logic unused_wb_load;
  assign unused_wb_load = wb_r.mem_read;

  function automatic logic hit(input logic wr, input logic [REG_AW-1:0] dst,
                               input logic [REG_AW-1:0] r);
    return wr && (dst == r) && !((ZERO_REG != 0) && (r == '0));
  endfunction

  logic ex_wr, mem_wr, wb_wr;
  assign ex_wr  = vld_pipe[0] & ex_r.reg_write;
  assign mem_wr = vld_pipe[1] & mem_r.reg_write;
  assign wb_wr  = vld_pipe[2] & wb_r.reg_write;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [REG_AW-1:0] is, es;
    assign is = id_src[p*REG_AW +: REG_AW];
    assign es = ex_src[p*REG_AW +: REG_AW];

    // EX/MEM wins over MEM/WB: it carries the younger write.
    always_comb begin
      forward[2*p +: 2] = 2'd0;
      if (ex_used[p]) begin
        if (hit(mem_wr, mem_r.dst, es))     forward[2*p +: 2] = 2'd2;
        else if (hit(wb_wr, wb_r.dst, es))  forward[2*p +: 2] = 2'd1;
      end
    end

    assign rf_bypass[p] = id_valid & id_src_used[p] & hit(wb_wr, wb_r.dst, is);
    assign load_use[p]  = id_src_used[p] & ex_r.mem_read & hit(ex_wr, ex_r.dst, is);
  end

  assign hazard = id_valid & (|load_use);
  // A taken branch squashes the ID instruction, so its load-use stall is moot.
  assign stall  = reset & (hold | (hazard & ~ex_branchTaken));
  assign bubble = reset & ~hold & (hazard | ex_branchTaken);
  assign flush  = reset & ~hold & ex_branchTaken;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe    <= '0;
      ex_r        <= '0;
      mem_r       <= '0;
      wb_r        <= '0;
      ex_src      <= '0;
      ex_used     <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (!hold) begin
      vld_pipe <= {vld_pipe[1:0], id_valid & ~bubble};
      wb_r     <= mem_r;
      mem_r    <= ex_r;
      if (bubble) begin
        ex_r    <= '0;
        ex_src  <= '0;
        ex_used <= '0;
      end else begin
        ex_r.dst       <= id_dst;
        ex_r.reg_write <= id_regWrite;
        ex_r.mem_read  <= id_memRead;
        ex_src         <= id_src;
        ex_used        <= id_src_used;
      end
      if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      if (flush && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations (default, and ZERO_REG=1/CNT_W=2)
// share one stimulus stream and are checked against an instruction-level model.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0, reset = 1'b0, hold = 1'b0, id_valid = 1'b0;
  logic [7:0] id_src = '0;
  logic [1:0] id_src_used = '0;
  logic [3:0] id_dst = '0;
  logic       id_regWrite = 1'b0, id_memRead = 1'b0, ex_branchTaken = 1'b0;

  logic        stall0, bubble0, flush0, stall1, bubble1, flush1;
  logic [3:0]  forward0, forward1;
  logic [1:0]  rf_bypass0, rf_bypass1;
  logic [15:0] stall_count0, flush_count0;
  logic [1:0]  stall_count1, flush_count1;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.REG_AW(4), .READ_PORTS(2), .CNT_W(16), .ZERO_REG(0)) dut0 (
    .clock(clock), .reset(reset), .hold(hold), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dst(id_dst), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .ex_branchTaken(ex_branchTaken), .stall(stall0),
    .bubble(bubble0), .flush(flush0), .forward(forward0), .rf_bypass(rf_bypass0),
    .stall_count(stall_count0), .flush_count(flush_count0));

  pipe_hazard_ctrl #(.REG_AW(4), .READ_PORTS(2), .CNT_W(2), .ZERO_REG(1)) dut1 (
    .clock(clock), .reset(reset), .hold(hold), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dst(id_dst), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .ex_branchTaken(ex_branchTaken), .stall(stall1),
    .bubble(bubble1), .flush(flush1), .forward(forward1), .rf_bypass(rf_bypass1),
    .stall_count(stall_count1), .flush_count(flush_count1));

  // Instruction in flight; mp[k][0..2] = instructions now in EX, MEM, WB for config k.
  typedef struct packed {
    logic       v;
    logic [3:0] dst;
    logic       rw;
    logic       mr;
    logic [7:0] src;
    logic [1:0] used;
  } ins_t;

  typedef struct packed {
    logic       st, bb, fl;
    logic [3:0] fw;
    logic [1:0] byp;
  } exp_t;

  ins_t mp [2][3];
  int   sc [2];
  int   fc [2];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit writes(int k, ins_t x, logic [3:0] r);
    return x.v && x.rw && x.dst == r && !(k == 1 && r == 4'd0);
  endfunction

  function automatic exp_t model(int k);
    exp_t       e;
    bit         haz;
    logic [3:0] s, es;
    e = '0;
    haz = 0;
    if (!reset) return e;
    for (int p = 0; p < 2; p++) begin
      s  = id_src[p*4 +: 4];
      es = mp[k][0].src[p*4 +: 4];
      if (id_src_used[p] && mp[k][0].mr && writes(k, mp[k][0], s)) haz = 1;
      if (id_valid && id_src_used[p] && writes(k, mp[k][2], s)) e.byp[p] = 1'b1;
      if (mp[k][0].used[p])
        e.fw[p*2 +: 2] = writes(k, mp[k][1], es) ? 2'd2 : writes(k, mp[k][2], es) ? 2'd1 : 2'd0;
    end
    haz  = haz && id_valid;
    e.st = hold || (haz && !ex_branchTaken);
    e.bb = !hold && (haz || ex_branchTaken);
    e.fl = !hold && ex_branchTaken;
    return e;
  endfunction

  always @(posedge clock or negedge reset) begin
    exp_t e;
    ins_t cur;
    int   mx;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 3; i++) mp[k][i] <= '0;
        sc[k] <= 0;
        fc[k] <= 0;
      end
    end else if (!hold) begin
      cur = '{v: id_valid, dst: id_dst, rw: id_regWrite, mr: id_memRead,
              src: id_src, used: id_src_used};
      for (int k = 0; k < 2; k++) begin
        e  = model(k);
        mx = (k == 0) ? 65535 : 3;
        if (e.st && sc[k] < mx) sc[k] <= sc[k] + 1;
        if (e.fl && fc[k] < mx) fc[k] <= fc[k] + 1;
        mp[k][2] <= mp[k][1];
        mp[k][1] <= mp[k][0];
        mp[k][0] <= e.bb ? '0 : cur;
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    e = model(0);
    chk("m0_stall", stall0, e.st);        chk("m0_bubble", bubble0, e.bb);
    chk("m0_flush", flush0, e.fl);        chk("m0_forward", forward0, e.fw);
    chk("m0_rf_bypass", rf_bypass0, e.byp);
    chk("m0_stall_count", stall_count0, sc[0]);
    chk("m0_flush_count", flush_count0, fc[0]);
    e = model(1);
    chk("m1_stall", stall1, e.st);        chk("m1_bubble", bubble1, e.bb);
    chk("m1_flush", flush1, e.fl);        chk("m1_forward", forward1, e.fw);
    chk("m1_rf_bypass", rf_bypass1, e.byp);
    chk("m1_stall_count", stall_count1, sc[1]);
    chk("m1_flush_count", flush_count1, fc[1]);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                     input logic [1:0] u, input logic [3:0] d, input logic rw, input logic mr);
    id_valid = v; id_src = {s1, s0}; id_src_used = u;
    id_dst = d;   id_regWrite = rw;  id_memRead = mr;
  endtask

  task automatic idle();
    put(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic put_ld();   // load r6 <- [r8]
    put(1'b1, 4'd8, 4'd0, 2'b01, 4'd6, 1'b1, 1'b0);
    id_memRead = 1'b1;
  endtask

  task automatic put_use();  // r7 = r6 + r1
    put(1'b1, 4'd6, 4'd1, 2'b11, 4'd7, 1'b1, 1'b0);
  endtask

  initial begin
    // reset state, with hold asserted to show reset wins
    hold = 1'b1;
    #2;
    chk("rst_stall", stall0, 0);        chk("rst_bubble", bubble0, 0);
    chk("rst_flush", flush0, 0);        chk("rst_stall_count", stall_count0, 0);
    repeat (2) @(posedge clock);
    #1; reset = 1'b1; hold = 1'b0;

    // ALU chain r3=r1+r2 ; r4=r3+r5
    put(1'b1, 4'd1, 4'd2, 2'b11, 4'd3, 1'b1, 1'b0);
    cyc(); put(1'b1, 4'd3, 4'd5, 2'b11, 4'd4, 1'b1, 1'b0);
    #1 chk("alu_no_stall", stall0, 0);
    cyc(); idle();
    #1 chk("alu_fwd_exmem", forward0[1:0], 2); chk("alu_stall", stall0, 0);
    repeat (3) cyc();

    // load-use
    put_ld();
    cyc(); put_use();
    #1 chk("lu_stall", stall0, 1); chk("lu_bubble", bubble0, 1); chk("lu_flush", flush0, 0);
    cyc();
    #1 chk("lu_stall_once", stall0, 0); chk("lu_bubble_once", bubble0, 0);
    cyc(); idle();
    #1 chk("lu_fwd_memwb", forward0[1:0], 1); chk("lu_stall_count", stall_count0, 1);
    repeat (3) cyc();

    // taken branch in the same cycle as a load-use hazard
    put_ld();
    cyc(); put_use(); ex_branchTaken = 1'b1;
    #1 chk("br_flush", flush0, 1); chk("br_bubble", bubble0, 1); chk("br_stall", stall0, 0);
    cyc(); idle(); ex_branchTaken = 1'b0;
    #1 chk("br_flush_count", flush_count0, 1); chk("br_stall_count", stall_count0, 1);
    repeat (3) cyc();

    // MEM and WB both write r2, EX reads r2; then only WB writes r2 and ID reads it
    put(1'b1, 4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b0);
    cyc();
    cyc(); put(1'b1, 4'd2, 4'd0, 2'b01, 4'd9, 1'b1, 1'b0);
    cyc(); idle();
    #1 chk("dbl_fwd", forward0[1:0], 2);
    cyc(); put(1'b1, 4'd0, 4'd2, 2'b10, 4'd10, 1'b0, 1'b0);
    #1 chk("wb_bypass", rf_bypass0, 2); chk("wb_bypass_fwd", forward0, 0);
    cyc(); idle();
    repeat (3) cyc();

    // freeze for 3 cycles during a load-use hazard
    put_ld();
    cyc(); put_use(); hold = 1'b1;
    #1 chk("hold_stall", stall0, 1); chk("hold_bubble", bubble0, 0);
    repeat (2) begin
      cyc();
      #1 chk("hold_stall_n", stall0, 1); chk("hold_count", stall_count0, 1);
    end
    cyc(); hold = 1'b0;
    #1 chk("resume_stall", stall0, 1); chk("resume_bubble", bubble0, 1);
    cyc();
    #1 chk("resume_clear", stall0, 0); chk("resume_count", stall_count0, 2);
    cyc(); idle();
    #1 chk("resume_fwd", forward0[1:0], 1);
    repeat (3) cyc();

    // reset during a stall
    put_ld();
    cyc(); put_use();
    #1 chk("pre_rst_stall", stall0, 1);
    #1 reset = 1'b0;
    #1 chk("mid_rst_stall", stall0, 0);  chk("mid_rst_bubble", bubble0, 0);
    chk("mid_rst_count", stall_count0, 0); chk("mid_rst_fwd", forward0, 0);
    cyc(); reset = 1'b1;
    #1 chk("post_rst_empty", stall0, 0);
    cyc(); idle();
    repeat (3) cyc();

    // r0 writer/reader: ignored only in the ZERO_REG=1 instance
    put(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b1, 1'b0);
    cyc(); put(1'b1, 4'd0, 4'd0, 2'b01, 4'd5, 1'b1, 1'b0);
    cyc(); idle();
    #1 chk("zr_fwd", forward1[1:0], 0); chk("nzr_fwd", forward0[1:0], 2);
    cyc(); put(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b1, 1'b1);
    cyc(); put(1'b1, 4'd0, 4'd0, 2'b01, 4'd5, 1'b1, 1'b0);
    #1 chk("zr_no_stall", stall1, 0); chk("nzr_stall", stall0, 1);
    cyc(); idle();
    repeat (3) cyc();

    // five more load-use stalls: 2-bit counter saturates at 3
    repeat (5) begin
      put_ld();
      cyc(); put_use();
      cyc();
      cyc(); idle();
      cyc();
    end
    #1 chk("sat_count", stall_count1, 3); chk("wide_count", stall_count0, 6);
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
